// File: rtl/rom_image_loader_if.sv
// rom_image_loader_if
//   Groups the HPS download stream, the pattern-RAM byte write port and the
//   session status outputs of rom_image_loader.
//   master : HPS / host side (drives ioctl_*, observes everything else)
//   slave  : loader side
//   AW must match the AW of the rom_image_loader instance it is bound to.
interface rom_image_loader_if #(
    parameter int AW = 16
);
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [15:0]   ioctl_dout;
    logic          ioctl_wait;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    logic          busy;
    logic          done;
    logic [AW:0]   byte_count;
    logic [7:0]    checksum;
    logic          overflow;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  ioctl_wait, mem_we, mem_addr, mem_data,
        input  busy, done, byte_count, checksum, overflow
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output ioctl_wait, mem_we, mem_addr, mem_data,
        output busy, done, byte_count, checksum, overflow
    );
endinterface

// File: rtl/rom_image_loader.sv
// rom_image_loader
//   Splits the 16-bit HPS download word stream into two byte writes to the
//   pattern RAM write port and keeps per-session status for the OSD.
//   Ports:
//     clock  : system clock, rising edge
//     reset  : synchronous, active-high
//     bus    : rom_image_loader_if.slave
//              ioctl_* in, ioctl_wait out, mem_we/mem_addr/mem_data out,
//              busy/done/byte_count/checksum/overflow out
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for an accepted in-range word strobe
//   LO    | writing low byte to base address, wait asserted
//   HI    | writing high byte to base+1, wait asserted
module rom_image_loader #(
    parameter int          AW    = 16,
    parameter logic [7:0]  INDEX = 8'd0
) (
    input  logic           clock,
    input  logic           reset,
    rom_image_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    localparam logic [AW:0]   CNT_MAX   = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [15:0]   word_q, word_d;
    logic          wait_q, wait_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic          accept_q;
    logic          pend_q, pend_d;

    logic accept, start, fall, in_range;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign accept   = bus.ioctl_download && (bus.ioctl_index == INDEX);
    assign start    = accept && !accept_q;
    assign fall     = !accept && accept_q;
    assign in_range = ((bus.ioctl_addr >> AW) == 25'd0);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        word_d  = word_q;
        wait_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        pend_d  = pend_q;

        // Session-start clears come first so a word strobed on the same
        // cycle is counted into the fresh session.
        if (start) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            ovf_d  = 1'b0;
            cnt_d  = '0;
            sum_d  = '0;
            pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (bus.ioctl_wr && accept) begin
                    if (in_range) begin
                        base_d  = bus.ioctl_addr[AW-1:0] & ~ADDR_ONE;
                        word_d  = bus.ioctl_dout;
                        wait_d  = 1'b1;
                        state_d = LO;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            LO: begin
                we_d    = 1'b1;
                addr_d  = base_q;
                data_d  = word_q[7:0];
                wait_d  = 1'b1;
                cnt_d   = sat_inc(cnt_d);
                sum_d   = sum_d + word_q[7:0];
                // Session ended mid-word: remember it, close after HI.
                if (fall) pend_d = 1'b1;
                state_d = HI;
            end
            HI: begin
                we_d    = 1'b1;
                addr_d  = base_q | ADDR_ONE;
                data_d  = word_q[15:8];
                wait_d  = 1'b1;
                cnt_d   = sat_inc(cnt_d);
                sum_d   = sum_d + word_q[15:8];
                // accept high here means a new session reopened; keep it open.
                if (!accept && (fall || pend_q)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pend_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            word_q   <= '0;
            wait_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            accept_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            word_q   <= word_d;
            wait_q   <= wait_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            accept_q <= accept;
            pend_q   <= pend_d;
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.byte_count = cnt_q;
    assign bus.checksum   = sum_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_rom_image_loader.sv
// tb_rom_image_loader
//   Directed bench for rom_image_loader (AW=16, INDEX=0). Expected byte writes
//   are queued as stimulus is driven and popped by a write monitor.
module tb_rom_image_loader;

    localparam int AW = 16;

    logic clock;
    logic reset;

    rom_image_loader_if #(.AW(AW)) bus ();

    rom_image_loader #(.AW(AW), .INDEX(8'd0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    logic [23:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic strobe(input logic [24:0] a, input logic [15:0] d);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
    endtask

    // Write monitor: every mem_we cycle must match the head of the scoreboard.
    always @(negedge clock) begin
        logic [23:0] e;
        if (bus.mem_we !== 1'b0) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h we %b expected no write",
                       bus.mem_addr, bus.mem_data, bus.mem_we);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_write", {8'h0, bus.mem_addr, bus.mem_data}, {8'h0, e});
            end
        end
    end

    initial begin
        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        tick();
        tick();
        chk("rst_wait",  bus.ioctl_wait, 0);
        chk("rst_we",    bus.mem_we, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_done",  bus.done, 0);
        chk("rst_ovf",   bus.overflow, 0);
        chk("rst_cnt",   bus.byte_count, 0);
        chk("rst_sum",   bus.checksum, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_data",  bus.mem_data, 0);
        reset = 1'b0;
        tick();

        // 1: single word, start and strobe in the same cycle
        bus.ioctl_download = 1'b1;
        strobe(25'h0, 16'hBEEF);
        push_wr(16'h0000, 8'hEF);
        push_wr(16'h0001, 8'hBE);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("t1_wait_k",   bus.ioctl_wait, 1);
        chk("t1_busy",     bus.busy, 1);
        chk("t1_we_k",     bus.mem_we, 0);
        tick();
        chk("t1_wait_k1",  bus.ioctl_wait, 1);
        tick();
        chk("t1_wait_k2",  bus.ioctl_wait, 1);
        tick();
        chk("t1_wait_k3",  bus.ioctl_wait, 0);
        chk("t1_we_k3",    bus.mem_we, 0);
        chk("t1_cnt",      bus.byte_count, 2);
        chk("t1_sum",      bus.checksum, 8'hAD);
        chk("t1_addr_hold", bus.mem_addr, 16'h0001);
        chk("t1_data_hold", bus.mem_data, 8'hBE);

        // 2: two words, then session end from IDLE
        bus.ioctl_download = 1'b0;
        tick();
        chk("t2_pre_done", bus.done, 1);
        chk("t2_pre_busy", bus.busy, 0);
        bus.ioctl_download = 1'b1;
        strobe(25'h0, 16'h0201);
        push_wr(16'h0000, 8'h01);
        push_wr(16'h0001, 8'h02);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("t2_start_done", bus.done, 0);
        chk("t2_start_busy", bus.busy, 1);
        chk("t2_start_cnt",  bus.byte_count, 0);
        chk("t2_start_sum",  bus.checksum, 0);
        tick();
        tick();
        tick();
        strobe(25'h2, 16'h0403);
        push_wr(16'h0002, 8'h03);
        push_wr(16'h0003, 8'h04);
        tick();
        bus.ioctl_wr = 1'b0;
        tick();
        tick();
        tick();
        bus.ioctl_download = 1'b0;
        tick();
        chk("t2_done", bus.done, 1);
        chk("t2_busy", bus.busy, 0);
        chk("t2_cnt",  bus.byte_count, 4);
        chk("t2_sum",  bus.checksum, 8'h0A);

        // 3: out-of-range word sets sticky overflow, next start clears it
        bus.ioctl_download = 1'b1;
        strobe(25'h10000, 16'h1234);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("t3_ovf",  bus.overflow, 1);
        chk("t3_wait", bus.ioctl_wait, 0);
        tick();
        chk("t3_wait2", bus.ioctl_wait, 0);
        chk("t3_ovf_sticky", bus.overflow, 1);
        bus.ioctl_download = 1'b0;
        tick();
        bus.ioctl_download = 1'b1;
        tick();
        chk("t3_ovf_cleared", bus.overflow, 0);
        chk("t3_busy", bus.busy, 1);
        bus.ioctl_download = 1'b0;
        tick();
        chk("t3_done", bus.done, 1);

        // 4: wrong index and download-low strobes are ignored
        bus.ioctl_index    = 8'd1;
        bus.ioctl_download = 1'b1;
        tick();
        strobe(25'h4, 16'h5555);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("t4_wait", bus.ioctl_wait, 0);
        tick();
        tick();
        chk("t4_busy", bus.busy, 0);
        chk("t4_done", bus.done, 1);
        chk("t4_cnt",  bus.byte_count, 0);
        bus.ioctl_index    = 8'd0;
        bus.ioctl_download = 1'b0;
        strobe(25'h6, 16'h6666);
        tick();
        bus.ioctl_wr = 1'b0;
        chk("t4_nodl_wait", bus.ioctl_wait, 0);
        tick();

        // 5: download falls one cycle after the strobe
        bus.ioctl_download = 1'b1;
        strobe(25'h10, 16'hA55A);
        push_wr(16'h0010, 8'h5A);
        push_wr(16'h0011, 8'hA5);
        tick();
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_download = 1'b0;
        chk("t5_busy_k",  bus.busy, 1);
        chk("t5_done_k",  bus.done, 0);
        tick();
        chk("t5_done_k1", bus.done, 0);
        chk("t5_busy_k1", bus.busy, 1);
        tick();
        chk("t5_done_k2", bus.done, 1);
        chk("t5_busy_k2", bus.busy, 0);
        tick();
        chk("t5_cnt",  bus.byte_count, 2);
        chk("t5_sum",  bus.checksum, 8'hFF);
        chk("t5_wait", bus.ioctl_wait, 0);

        // 7: odd address forced even; strobes during LO/HI ignored
        bus.ioctl_download = 1'b1;
        strobe(25'h7, 16'h1122);
        push_wr(16'h0006, 8'h22);
        push_wr(16'h0007, 8'h11);
        tick();
        strobe(25'h40, 16'hFFFF);
        tick();
        tick();
        bus.ioctl_wr = 1'b0;
        tick();
        chk("t7_cnt",  bus.byte_count, 2);
        chk("t7_sum",  bus.checksum, 8'h33);
        chk("t7_wait", bus.ioctl_wait, 0);
        chk("t7_addr", bus.mem_addr, 16'h0007);

        // 6: reset while in LO abandons the word
        strobe(25'h100, 16'h7788);
        tick();
        bus.ioctl_wr = 1'b0;
        reset = 1'b1;
        chk("t6_wait_pre", bus.ioctl_wait, 1);
        tick();
        chk("t6_we",   bus.mem_we, 0);
        chk("t6_wait", bus.ioctl_wait, 0);
        chk("t6_cnt",  bus.byte_count, 0);
        chk("t6_sum",  bus.checksum, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_ovf",  bus.overflow, 0);
        chk("t6_addr", bus.mem_addr, 0);
        chk("t6_data", bus.mem_data, 0);
        reset = 1'b0;
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        tick();
        chk("t6_we_after", bus.mem_we, 0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_image_loader.md
Name: rom_image_loader

Overview:
- Write-side counterpart to the team's synchronous read-only pattern-ROM block.
- Takes the MiSTer HPS file-download stream of 16-bit words and splits each word into two byte writes to the write port of the pattern RAM.
- The video side then reads the RAM unchanged.
- Also tracks session status (busy/done, byte count, checksum, overflow) for the OSD and debug.

Parameters:
- AW, 16: byte address width of the target memory (memory depth 2**AW bytes, 8-bit data); AW >= 1.
- INDEX, 8'd0: ioctl_index value this loader accepts; other indexes are ignored.

Ports:
- clock  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  high for the duration of an HPS download session.
- ioctl_index  in  8  file index of the current session.
- ioctl_wr  in  1  one-cycle word strobe.
- ioctl_addr  in  25  byte address of the word; always even.
- ioctl_dout  in  16  word data; the low byte goes to the even address.
- ioctl_wait  out  1  registered back-pressure to the HPS.
- mem_we  out  1  registered byte write enable.
- mem_addr  out  AW  registered byte write address.
- mem_data  out  8  registered write data.
- busy  out  1  high while an accepted session is open.
- done  out  1  sticky completion flag.
- byte_count  out  AW+1  number of bytes written this session.
- checksum  out  8  modulo-256 sum of bytes written this session.
- overflow  out  1  sticky flag: a word addressed beyond memory depth was seen.

Behaviour:
- Reset (synchronous, active high): state=IDLE. ioctl_wait, mem_we, busy, done, overflow = 0. mem_addr, mem_data, byte_count, checksum = 0. A partially written word is abandoned. Reset has priority over every other event in the same cycle.
- Accept condition: ioctl_download & (ioctl_index==INDEX).
- Session start: on the rising edge of the accept condition (previous sample low), same edge: busy=1, done=0, overflow=0, byte_count=0, checksum=0.
- State machine has three states: IDLE, LO, HI.
- IDLE:
  - Transition fires when ioctl_wr & accept & ioctl_addr[24:AW]==0.
  - Latch base=ioctl_addr[AW-1:0] and word=ioctl_dout.
  - Set ioctl_wait=1, go to LO.
  - With a strobe sampled at edge k: ioctl_wait=1 after edge k.
- LO: mem_we=1, mem_addr=base, mem_data=word[7:0]. Visible after edge k+1. Go to HI.
- HI: mem_we=1, mem_addr=base+1, mem_data=word[15:8]. Visible after edge k+2. Go to IDLE.
- After edge k+3: mem_we=0 and ioctl_wait=0. mem_addr and mem_data hold their last values.
- Per written byte: byte_count += 1 and checksum += data byte, mod 256. Both update on the same edge that asserts the write. byte_count saturates at 2**AW.
- Out-of-range word (ioctl_addr[24:AW]!=0) in IDLE with accept: no write, no wait, overflow=1 (sticky until next session start or reset).
- ioctl_wr while in LO or HI: ignored. This is a protocol violation by the HPS; the loader must not corrupt the in-flight word.
- ioctl_wr without accept (wrong index or download low): ignored.
- Address wrap: base is even, so base+1 never wraps. An odd ioctl_addr is forced even (bit 0 ignored).
- Odd-length files: the padding high byte is written; byte_count is always even.
- Session end: accept condition falls.
  - If state is IDLE: busy=0, done=1 on that edge.
  - If state is LO or HI: the in-flight word completes. busy=0, done=1 on the edge that returns the FSM to IDLE.
- done stays high until the next session start or reset.
- Accept rising and ioctl_wr in the same cycle: session-start clears apply first, and the word is accepted in that same cycle.

Test Plan:
1. Reset, then download index 0 with one word addr=0x0000, dout=0xBEEF -> wait high 3 cycles. Write (0x0000, 0xEF) then (0x0001, 0xBE). byte_count=2, checksum=0xAD.
2. Words 0x0201 at addr 0 and 0x0403 at addr 2, strobes 4 cycles apart, then download falls -> bytes 01,02,03,04 at addrs 0..3. byte_count=4, checksum=0x0A, done=1, busy=0.
3. AW=16, word at ioctl_addr=0x10000 -> mem_we never asserts, ioctl_wait stays 0, overflow=1. A following session start clears overflow.
4. Download with ioctl_index=1 (INDEX=0) plus strobes -> no writes, busy stays 0, done unchanged.
5. Download falls one cycle after a strobe -> both bytes still written. done rises on the edge the FSM returns to IDLE, not before.
6. Reset asserted in the cycle state=LO -> next cycle mem_we=0, ioctl_wait=0, all counters 0. No HI write occurs.
